// File: rtl/lsu_mem_port_if.sv
// lsu_mem_port_if: execute-stage request / writeback-stage response channel
// of the load/store unit. master = core side, slave = LSU side.
interface lsu_mem_port_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_store;
   logic [2:0]            req_funct3;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [31:0]           req_wdata;
   logic                  resp_valid;
   logic [31:0]           resp_rdata;
   logic                  resp_fault;

   modport master (
      output req_valid, req_store, req_funct3, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_fault
   );

   modport slave (
      input  req_valid, req_store, req_funct3, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_fault
   );
endinterface

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: single-outstanding RV32 load/store unit in front of a
// word-addressed RAM with byte-lane enables and a shared tri-state data bus.
// Optional build macro MISALIGNED_SPLIT_EN: word-crossing halves/words are
// split over two RAM cycles (W, then W+1) instead of faulting.
module lsu_mem_port #(
   parameter int ADDR_WIDTH     = 32,
   parameter int MEM_ADDR_WIDTH = 30
) (
   input  logic                      clk,
   input  logic                      rst,
   lsu_mem_port_if.slave             core,
   output logic                      mem_wen,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
   output logic [3:0]                mem_byte_en,
   inout  wire  [31:0]               mem_data
);
   typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

   state_t                    state;
   logic                      st_store;
   logic [2:0]                st_funct3;
   logic [1:0]                st_k;
   logic                      st_fault;
   logic                      st_split;
   logic [3:0]                st_hi_en;
   logic                      wen_q;
   logic [3:0]                be_q;
   logic [MEM_ADDR_WIDTH-1:0] addr_q;
   logic [31:0]               drv_q;
   logic [31:0]               buf_q;

   function automatic logic [31:0] rotl8(input logic [31:0] d, input logic [1:0] k);
      case (k)
         2'd0:    rotl8 = d;
         2'd1:    rotl8 = {d[23:0], d[31:24]};
         2'd2:    rotl8 = {d[15:0], d[31:16]};
         default: rotl8 = {d[7:0],  d[31:8]};
      endcase
   endfunction

   function automatic logic [31:0] rotr8(input logic [31:0] d, input logic [1:0] k);
      case (k)
         2'd0:    rotr8 = d;
         2'd1:    rotr8 = {d[7:0],  d[31:8]};
         2'd2:    rotr8 = {d[15:0], d[31:16]};
         default: rotr8 = {d[23:0], d[31:24]};
      endcase
   endfunction

   // funct3[2] selects zero-extension for the byte/half forms
   function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] d);
      case (f3[1:0])
         2'b00:   extend = f3[2] ? {24'h0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
         2'b01:   extend = f3[2] ? {16'h0, d[15:0]} : {{16{d[15]}}, d[15:0]};
         default: extend = d;
      endcase
   endfunction

   logic [1:0] in_k;
   logic       in_illegal;
   logic       in_misal;
   logic       in_split;
   logic       in_fault;
   logic [3:0] in_mask;
   logic [7:0] in_lanes;

   // Decode the presented request: legality, alignment and lane masks for
   // both possible RAM cycles (low nibble = word W, high nibble = word W+1).
   always_comb begin
      in_k = core.req_addr[1:0];
      if (core.req_store)
         in_illegal = core.req_funct3 > 3'b010;
      else
         in_illegal = (core.req_funct3 == 3'b011) || (core.req_funct3[2:1] == 2'b11);
      case (core.req_funct3[1:0])
         2'b00:   in_mask = 4'b0001;
         2'b01:   in_mask = 4'b0011;
         default: in_mask = 4'b1111;
      endcase
      in_misal = 1'b0;
      in_split = 1'b0;
`ifdef MISALIGNED_SPLIT_EN
      if (core.req_funct3[1:0] == 2'b01)
         in_split = (in_k == 2'd3);
      else if (core.req_funct3[1:0] == 2'b10)
         in_split = (in_k != 2'd0);
      in_split = in_split & ~in_illegal;
`else
      if (core.req_funct3[1:0] == 2'b01)
         in_misal = in_k[0];
      else if (core.req_funct3[1:0] == 2'b10)
         in_misal = (in_k != 2'd0);
`endif
      in_fault = in_illegal | in_misal;
      in_lanes = {4'b0000, in_mask} << in_k;
   end

   logic [31:0] merged;
   logic [31:0] ld_data;

   // Merge the lanes the RAM drives this cycle into the rotated load buffer,
   // then realign and extend for the response.
   always_comb begin
      merged = buf_q;
      for (int i = 0; i < 4; i++)
         if (be_q[i]) merged[8*i +: 8] = mem_data[8*i +: 8];
      ld_data = extend(st_funct3, rotr8(merged, st_k));
   end

   // rst gates the RAM strobes immediately so an access cut short by reset
   // never commits at the edge that takes the reset.
   assign mem_wen        = wen_q & ~rst;
   assign mem_byte_en    = be_q & {4{~rst}};
   assign mem_addr       = addr_q;
   assign mem_data       = mem_wen ? drv_q : 32'bz;
   assign core.req_ready = (state == IDLE) & ~rst;

   // Access FSM: IDLE -> ACC1 [-> ACC2] -> RESP -> IDLE, all outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         st_store        <= 1'b0;
         st_funct3       <= 3'b0;
         st_k            <= 2'b0;
         st_fault        <= 1'b0;
         st_split        <= 1'b0;
         st_hi_en        <= 4'b0;
         wen_q           <= 1'b0;
         be_q            <= 4'b0;
         addr_q          <= '0;
         drv_q           <= 32'b0;
         buf_q           <= 32'b0;
         core.resp_valid <= 1'b0;
         core.resp_rdata <= 32'b0;
         core.resp_fault <= 1'b0;
      end else begin
         core.resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (core.req_valid) begin
                  st_store  <= core.req_store;
                  st_funct3 <= core.req_funct3;
                  st_k      <= in_k;
                  st_fault  <= in_fault;
                  st_split  <= in_split;
                  st_hi_en  <= in_lanes[7:4];
                  addr_q    <= core.req_addr[MEM_ADDR_WIDTH+1:2];
                  // faulting requests still spend a dead ACC1 cycle, but with
                  // no lanes enabled the RAM is never touched
                  be_q      <= in_fault ? 4'b0 : in_lanes[3:0];
                  wen_q     <= ~in_fault & core.req_store;
                  drv_q     <= rotl8(core.req_wdata, in_k);
                  buf_q     <= 32'b0;
                  state     <= ACC1;
               end
            end
            ACC1, ACC2: begin
               buf_q <= merged;
               if (state == ACC1 && st_split) begin
                  addr_q <= addr_q + 1'b1;
                  be_q   <= st_hi_en;
                  state  <= ACC2;
               end else begin
                  wen_q           <= 1'b0;
                  be_q            <= 4'b0;
                  core.resp_valid <= 1'b1;
                  core.resp_fault <= st_fault;
                  core.resp_rdata <= (st_store | st_fault) ? 32'b0 : ld_data;
                  state           <= RESP;
               end
            end
            default: begin
               core.resp_rdata <= 32'b0;
               core.resp_fault <= 1'b0;
               state           <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: directed vectors with a response scoreboard and a RAM-cycle
// scoreboard, each drained by its own monitor on the falling edge.
module tb_lsu_mem_port;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ram_init = 1'b1;
   always #5 clk = ~clk;

   lsu_mem_port_if #(.ADDR_WIDTH(32)) core ();
   logic        mem_wen;
   logic [29:0] mem_addr;
   logic [3:0]  mem_byte_en;
   wire  [31:0] mem_data;

   lsu_mem_port #(.ADDR_WIDTH(32), .MEM_ADDR_WIDTH(30)) dut (
      .clk(clk), .rst(rst), .core(core), .mem_wen(mem_wen),
      .mem_addr(mem_addr), .mem_byte_en(mem_byte_en), .mem_data(mem_data)
   );

   typedef struct { logic [31:0] rdata; logic fault; int cyc; } rexp_t;
   typedef struct { logic wen; logic [29:0] addr; logic [3:0] be; logic [31:0] data; } mexp_t;
   rexp_t rq[$];
   mexp_t mq[$];
   int vecs = 0;
   int errs = 0;
   int cyc  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // RAM model: 64 words, drives the whole word whenever a read lane is enabled
   logic [31:0] ram [0:63];
   assign mem_data = (!mem_wen && mem_byte_en != 4'b0) ? ram[mem_addr[5:0]] : 32'bz;
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 64; i++) ram[i] <= 32'hA5A5_0000 | i;
      end else if (mem_wen) begin
         for (int i = 0; i < 4; i++)
            if (mem_byte_en[i]) ram[mem_addr[5:0]][8*i +: 8] <= mem_data[8*i +: 8];
      end
   end

   // response monitor
   always @(negedge clk) begin
      rexp_t e;
      if (core.resp_valid) begin
         vecs++;
         if (rq.size() == 0) begin
            errs++;
            $display("FAIL resp_unexpected: rdata %h fault %0d at cycle %0d, none required", core.resp_rdata, core.resp_fault, cyc);
         end else begin
            e = rq.pop_front();
            if (core.resp_rdata !== e.rdata || core.resp_fault !== e.fault || cyc != e.cyc) begin
               errs++;
               $display("FAIL resp: got rdata %h fault %0d cycle %0d, expected rdata %h fault %0d cycle %0d",
                        core.resp_rdata, core.resp_fault, cyc, e.rdata, e.fault, e.cyc);
            end
         end
      end
   end

   // RAM-cycle monitor
   always @(negedge clk) begin
      mexp_t m;
      logic [31:0] lm;
      if (mem_wen || mem_byte_en != 4'b0) begin
         vecs++;
         if (mq.size() == 0) begin
            errs++;
            $display("FAIL mem_unexpected: wen %0d addr %h be %b, no RAM cycle required", mem_wen, mem_addr, mem_byte_en);
         end else begin
            m = mq.pop_front();
            lm = {{8{m.be[3]}}, {8{m.be[2]}}, {8{m.be[1]}}, {8{m.be[0]}}};
            if (mem_wen !== m.wen || mem_addr !== m.addr || mem_byte_en !== m.be ||
                (m.wen && ((mem_data & lm) !== (m.data & lm)))) begin
               errs++;
               $display("FAIL mem: got wen %0d addr %h be %b data %h, expected wen %0d addr %h be %b data %h",
                        mem_wen, mem_addr, mem_byte_en, mem_data, m.wen, m.addr, m.be, m.data);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic exp_mem(input logic w, input logic [29:0] a, input logic [3:0] be, input logic [31:0] d);
      mq.push_back('{w, a, be, d});
   endtask

   // called on a falling edge; lat = 0 means no response is expected
   task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] er, input logic ef, input int lat);
      int n = 0;
      while (!core.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!core.req_ready) begin
         vecs++;
         errs++;
         $display("FAIL ready_timeout: req_ready 0 after %0d cycles, required 1", n);
         return;
      end
      core.req_valid  = 1'b1;
      core.req_store  = st;
      core.req_funct3 = f3;
      core.req_addr   = a;
      core.req_wdata  = wd;
      if (lat != 0) rq.push_back('{er, ef, cyc + lat});
      @(negedge clk);
      core.req_valid = 1'b0;
   endtask

   localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

   initial begin
      int n;
      core.req_valid = 1'b0; core.req_store = 1'b0; core.req_funct3 = 3'b0;
      core.req_addr = 32'b0; core.req_wdata = 32'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'b0, core.req_ready}, 32'd0);
      chk("rst_wen",   {31'b0, mem_wen}, 32'd0);
      chk("rst_be",    {28'b0, mem_byte_en}, 32'd0);
      chk("rst_addr",  {2'b0, mem_addr}, 32'd0);
      chk("rst_resp",  {30'b0, core.resp_valid, core.resp_fault}, 32'd0);
      chk("rst_rdata", core.resp_rdata, 32'd0);
      rst = 1'b0;
      ram_init = 1'b0;
      @(negedge clk);

      exp_mem(1, 30'd4, 4'b1111, 32'hDEADBEEF);
      issue(1, W, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2);
      exp_mem(0, 30'd4, 4'b1111, 32'h0);
      issue(0, W, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2);

      exp_mem(1, 30'd4, 4'b1000, 32'h80000000);
      issue(1, B, 32'h13, 32'h12345680, 32'h0, 0, 2);
      exp_mem(0, 30'd4, 4'b1000, 32'h0);
      issue(0, B, 32'h13, 32'h0, 32'hFFFFFF80, 0, 2);
      exp_mem(0, 30'd4, 4'b1000, 32'h0);
      issue(0, BU, 32'h13, 32'h0, 32'h00000080, 0, 2);
      exp_mem(0, 30'd4, 4'b1111, 32'h0);
      issue(0, W, 32'h10, 32'h0, 32'h80ADBEEF, 0, 2);

      exp_mem(1, 30'd4, 4'b1100, 32'h12340000);
      issue(1, H, 32'h12, 32'hFFFF1234, 32'h0, 0, 2);
      exp_mem(0, 30'd4, 4'b1100, 32'h0);
      issue(0, H, 32'h12, 32'h0, 32'h00001234, 0, 2);
      exp_mem(0, 30'd4, 4'b0011, 32'h0);
      issue(0, HU, 32'h10, 32'h0, 32'h0000BEEF, 0, 2);
      exp_mem(0, 30'd4, 4'b0011, 32'h0);
      issue(0, H, 32'h10, 32'h0, 32'hFFFFBEEF, 0, 2);
      exp_mem(0, 30'd4, 4'b0010, 32'h0);
      issue(0, B, 32'h11, 32'h0, 32'hFFFFFFBE, 0, 2);

`ifdef MISALIGNED_SPLIT_EN
      exp_mem(0, 30'd4, 4'b0110, 32'h0);
      issue(0, H, 32'h11, 32'h0, 32'h000034BE, 0, 2);
`else
      issue(0, H, 32'h11, 32'h0, 32'h0, 1, 2);
`endif

      issue(0, 3'b011, 32'h0, 32'h0, 32'h0, 1, 2);
      issue(0, 3'b110, 32'h4, 32'h0, 32'h0, 1, 2);
      issue(1, 3'b100, 32'h0, 32'h5555AAAA, 32'h0, 1, 2);

`ifdef MISALIGNED_SPLIT_EN
      exp_mem(0, 30'd4, 4'b1100, 32'h0);
      exp_mem(0, 30'd5, 4'b0011, 32'h0);
      issue(0, W, 32'h12, 32'h0, 32'h00051234, 0, 3);
`else
      issue(0, W, 32'h12, 32'h0, 32'h0, 1, 2);
`endif

      // reset in the middle of a store's RAM cycle
      exp_mem(1, 30'd5, 4'b1111, 32'h11111111);
      issue(1, W, 32'h14, 32'h11111111, 32'h0, 0, 0);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("midrst_wen",   {31'b0, mem_wen}, 32'd0);
      chk("midrst_be",    {28'b0, mem_byte_en}, 32'd0);
      chk("midrst_ready", {31'b0, core.req_ready}, 32'd0);
      @(negedge clk);
      chk("midrst_resp",  {31'b0, core.resp_valid}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      exp_mem(0, 30'd5, 4'b1111, 32'h0);
      issue(0, W, 32'h14, 32'h0, 32'hA5A50005, 0, 2);

`ifdef MISALIGNED_SPLIT_EN
      exp_mem(1, 30'd3, 4'b1100, 32'hCCDD0000);
      exp_mem(1, 30'd4, 4'b0011, 32'h0000AABB);
      issue(1, W, 32'h0E, 32'hAABBCCDD, 32'h0, 0, 3);
      exp_mem(0, 30'd3, 4'b1100, 32'h0);
      exp_mem(0, 30'd4, 4'b0011, 32'h0);
      issue(0, W, 32'h0E, 32'h0, 32'hAABBCCDD, 0, 3);
      exp_mem(0, 30'd3, 4'b1111, 32'h0);
      issue(0, W, 32'h0C, 32'h0, 32'hCCDD0003, 0, 2);
      exp_mem(0, 30'h3FFFFFFF, 4'b1000, 32'h0);
      exp_mem(0, 30'd0, 4'b0001, 32'h0);
      issue(0, H, 32'hFFFFFFFF, 32'h0, 32'h000000A5, 0, 3);
`else
      issue(1, W, 32'h0E, 32'hAABBCCDD, 32'h0, 1, 2);
      issue(0, W, 32'h0E, 32'h0, 32'h0, 1, 2);
      exp_mem(0, 30'd3, 4'b1111, 32'h0);
      issue(0, W, 32'h0C, 32'h0, 32'hA5A50003, 0, 2);
      issue(0, H, 32'hFFFFFFFF, 32'h0, 32'h0, 1, 2);
`endif

      n = 0;
      while ((rq.size() != 0 || mq.size() != 0) && n < 50) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      chk("resp_drained", rq.size(), 32'd0);
      chk("mem_drained",  mq.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
